// File: rtl/dct_quant_zigzag_pkg.sv
// Shared constants for the DCT quantize/zigzag stage: widths, zigzag LUT,
// JPEG luminance Q table, derived reciprocal table and FSM state encoding.
package dct_quant_zigzag_pkg;

    localparam int COEF_W  = 16;
    localparam int OUT_W   = 16;
    localparam int RECIP_W = 17;
    localparam int FRAC    = 16;
    localparam int MAG_W   = COEF_W + 1;
    localparam int PROD_W  = MAG_W + RECIP_W;
    localparam int NCOEF   = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2
    } state_t;

    // Zigzag position -> natural (row*8+col) index.
    localparam logic [5:0] ZZ [NCOEF] = '{
         0,  1,  8, 16,  9,  2,  3, 10,
        17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34,
        27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36,
        29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46,
        53, 60, 61, 54, 47, 55, 62, 63
    };

    // JPEG luminance quantization table, natural order.
    localparam logic [7:0] Q_TAB [NCOEF] = '{
        16,  11,  10,  16,  24,  40,  51,  61,
        12,  12,  14,  19,  26,  58,  60,  55,
        14,  13,  16,  24,  40,  57,  69,  56,
        14,  17,  22,  29,  51,  87,  80,  62,
        18,  22,  37,  56,  68, 109, 103,  77,
        24,  35,  55,  64,  81, 104, 113,  92,
        49,  64,  78,  87, 103, 121, 120, 101,
        72,  92,  95,  98, 112, 100, 103,  99
    };

    // RECIP[n] = round(2^FRAC / Q[n]), folded to constants at elaboration.
    function automatic logic [NCOEF*RECIP_W-1:0] build_recip();
        logic [NCOEF*RECIP_W-1:0] r;
        int v;
        r = '0;
        for (int i = 0; i < NCOEF; i++) begin
            v = ((1 << FRAC) + int'(Q_TAB[i]) / 2) / int'(Q_TAB[i]);
            r[i*RECIP_W +: RECIP_W] = v[RECIP_W-1:0];
        end
        return r;
    endfunction

    localparam logic [NCOEF*RECIP_W-1:0] RECIP_FLAT = build_recip();

endpackage

// File: rtl/dct_quant_zigzag_quant.sv
// Combinational quantizer for one coefficient: sign/magnitude reciprocal
// multiply with round-half-up on the magnitude, sign reapplied afterwards.
module dct_quant_unit
    import dct_quant_zigzag_pkg::*;
(
    input  logic [COEF_W-1:0]  coeff,
    input  logic [RECIP_W-1:0] recip,
    output logic [OUT_W-1:0]   q
);

    logic              neg;
    logic [MAG_W-1:0]  ext;
    logic [MAG_W-1:0]  mag;
    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] rounded;
    logic [OUT_W-1:0]  qmag;

    always_comb begin
        neg     = coeff[COEF_W-1];
        // 17-bit magnitude so that -32768 is representable.
        ext     = {coeff[COEF_W-1], coeff};
        mag     = neg ? -ext : ext;
        prod    = PROD_W'(mag) * PROD_W'(recip);
        rounded = prod + PROD_W'(1 << (FRAC - 1));
        qmag    = OUT_W'(rounded >> FRAC);
        q       = neg ? -qmag : qmag;
    end

endmodule

// File: rtl/dct_quant_zigzag.sv
// Quantize one 8x8 DCT block and stream it out in zigzag order.
// Define DCT_EOB_EN to stop the stream at the last nonzero zigzag index.
module dct_quant_zigzag
    import dct_quant_zigzag_pkg::*;
(
    input  logic              Clock,
    input  logic              reset,
    input  logic              start,
    input  logic [1023:0]     coeff_in,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_coeff,
    output logic [5:0]        out_index,
    output logic              out_last
);

    state_t             state;
    state_t             state_next;
    logic [5:0]         ptr;
    logic [5:0]         final_idx;
    logic [5:0]         nat;
    logic [COEF_W-1:0]  cbuf [NCOEF];
    logic [OUT_W-1:0]   qbuf [NCOEF];
    logic [RECIP_W-1:0] recip;
    logic [OUT_W-1:0]   q;
    logic               accept;

`ifdef DCT_EOB_EN
    logic [5:0] last_nz;
    assign final_idx = last_nz;
`else
    assign final_idx = 6'd63;
`endif

    // Handshake: a beat transfers on a rising edge where out_valid && out_ready;
    // while out_ready is low the presented beat (coeff, index, last) is held.
    assign accept    = out_valid && out_ready;
    assign busy      = (state != IDLE);
    assign out_valid = (state == EMIT);
    assign out_coeff = out_valid ? qbuf[ptr] : '0;
    assign out_index = out_valid ? ptr : 6'd0;
    assign out_last  = out_valid && (ptr == final_idx);

    assign nat   = ZZ[ptr];
    assign recip = RECIP_FLAT[int'(nat)*RECIP_W +: RECIP_W];

    dct_quant_unit u_quant (
        .coeff (cbuf[nat]),
        .recip (recip),
        .q     (q)
    );

    always_ff @(posedge Clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SCAN;
            SCAN:    if (ptr == 6'd63) state_next = EMIT;
            EMIT:    if (accept && (ptr == final_idx)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (reset) begin
            ptr <= 6'd0;
`ifdef DCT_EOB_EN
            last_nz <= 6'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    ptr <= 6'd0;
`ifdef DCT_EOB_EN
                    if (start) last_nz <= 6'd0;
`endif
                end
                // ptr wraps from 63 to 0 exactly as EMIT begins.
                SCAN: begin
                    ptr <= ptr + 6'd1;
`ifdef DCT_EOB_EN
                    if (q != '0) last_nz <= ptr;
`endif
                end
                EMIT: if (accept) ptr <= (ptr == final_idx) ? 6'd0 : ptr + 6'd1;
                default: ptr <= 6'd0;
            endcase
        end
    end

    // Data buffers carry no reset; they are always written before being read.
    always_ff @(posedge Clock) begin
        if (state == IDLE && start && !reset) begin
            for (int i = 0; i < NCOEF; i++) cbuf[i] <= coeff_in[i*COEF_W +: COEF_W];
        end
        if (state == SCAN) qbuf[ptr] <= q;
    end

endmodule

// File: tb/tb_dct_quant_zigzag.sv
// Directed bench for dct_quant_zigzag: hand-computed quantized blocks,
// latency, backpressure hold, start-while-busy and reset-abort.
module tb_dct_quant_zigzag;

    logic          Clock = 1'b0;
    logic          reset;
    logic          start;
    logic [1023:0] coeff_in;
    logic          busy;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   out_coeff;
    logic [5:0]    out_index;
    logic          out_last;

    int            total = 0;
    int            bad   = 0;
    logic [22:0]   exp_q [$];
    logic [15:0]   ev [64];
    logic [1023:0] blk;

    always #5 Clock = ~Clock;

    dct_quant_zigzag dut (
        .Clock     (Clock),
        .reset     (reset),
        .start     (start),
        .coeff_in  (coeff_in),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_coeff (out_coeff),
        .out_index (out_index),
        .out_last  (out_last)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_block();
        blk = '0;
        for (int i = 0; i < 64; i++) ev[i] = 16'd0;
        exp_q.delete();
    endtask

    task automatic set_nat(input int r, input int c, input logic [15:0] v);
        blk[(r*8+c)*16 +: 16] = v;
    endtask

    // Expected beats {last, index, value} in zigzag order.
    task automatic build_exp();
        int fin;
`ifdef DCT_EOB_EN
        fin = 0;
        for (int z = 0; z < 64; z++) if (ev[z] != 16'd0) fin = z;
`else
        fin = 63;
`endif
        for (int z = 0; z <= fin; z++) exp_q.push_back({(z == fin), 6'(z), ev[z]});
    endtask

    task automatic start_block(input bit glitch);
        int cyc;
        @(negedge Clock);
        coeff_in = blk;
        start    = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            if (glitch && cyc == 10) begin
                start    = 1'b1;
                coeff_in = ~blk;
            end else begin
                start = 1'b0;
            end
            @(negedge Clock);
            cyc++;
        end
        start = 1'b0;
        check("first_beat_latency", 32'(cyc), 32'd64);
    endtask

    task automatic drain(input int maxb, input bit bp);
        logic [3:0] pat;
        int k, cyc, n;
        pat = 4'b1001;
        k = 0; cyc = 0; n = 0;
        while (exp_q.size() > 0 && n < maxb && cyc < 1000) begin
            check("beat", {8'd0, out_valid, out_last, out_index, out_coeff}, {8'd0, 1'b1, exp_q[0]});
            out_ready = bp ? pat[k % 4] : 1'b1;
            k++;
            if (out_ready) begin
                void'(exp_q.pop_front());
                n++;
            end
            @(negedge Clock);
            cyc++;
        end
        out_ready = 1'b0;
        check("drain_in_budget", {31'd0, (cyc < 1000)}, 32'd1);
        if (exp_q.size() == 0)
            check("idle_after_last", {30'd0, busy, out_valid}, 32'd0);
    endtask

    task automatic run_block(input bit glitch, input bit bp);
        build_exp();
        start_block(glitch);
        drain(1000, bp);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        coeff_in  = '0;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        check("reset_state", {8'd0, busy, out_valid, out_last, out_index, out_coeff}, 32'd0);
        reset = 1'b0;

        // DC 100 / Q16 -> 6
        clear_block(); set_nat(0, 0, 16'd100); ev[0] = 16'd6;
        run_block(1'b0, 1'b0);

        // (0,1)=-200 / Q11 -> -18 at zigzag 1
        clear_block(); set_nat(0, 1, -16'sd200); ev[1] = -16'sd18;
        run_block(1'b0, 1'b0);

        // Extremes
        clear_block(); set_nat(0, 0, 16'h7fff); ev[0] = 16'd2048;
        run_block(1'b0, 1'b0);
        clear_block(); set_nat(0, 0, 16'h8000); ev[0] = -16'sd2048;
        run_block(1'b0, 1'b0);

        // Rounding edges: -8/Q16 -> -1, (0,2)=7/Q10 -> 1 at zigzag 5
        clear_block(); set_nat(0, 0, -16'sd8); ev[0] = -16'sd1;
        set_nat(0, 2, 16'd7); ev[5] = 16'd1;
        run_block(1'b0, 1'b0);

        // Mixed block with backpressure: (1,0)=-50/Q12 -> -4 at z2, (7,7)=1000/Q99 -> 10 at z63
        clear_block(); set_nat(1, 0, -16'sd50); ev[2] = -16'sd4;
        set_nat(7, 7, 16'd1000); ev[63] = 16'd10;
        set_nat(0, 0, 16'd100); ev[0] = 16'd6;
        run_block(1'b0, 1'b1);

        // start pulsed (with different data) during SCAN is ignored
        clear_block(); set_nat(0, 1, -16'sd200); ev[1] = -16'sd18;
        set_nat(7, 7, 16'd1000); ev[63] = 16'd10;
        run_block(1'b1, 1'b0);

        // Reset during EMIT aborts, then a full block runs cleanly
        clear_block(); set_nat(1, 0, -16'sd50); ev[2] = -16'sd4;
        set_nat(7, 7, 16'd1000); ev[63] = 16'd10;
        build_exp();
        start_block(1'b0);
        drain(3, 1'b0);
        reset = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        check("reset_abort", {8'd0, busy, out_valid, out_last, out_index, out_coeff}, 32'd0);
        reset = 1'b0;
        exp_q.delete();
        run_block(1'b0, 1'b0);

        // All-zero block
        clear_block();
        run_block(1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
